// File: rtl/dram_csr_bank.sv
// Per-channel DRAM controller CSR bank: fixed-latency CSR read port, write port,
// and the correctable-error counter with threshold interrupt.
module dram_csr_bank #(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        ucb_dram_rd_req_vld,
  input  logic        ucb_dram_wr_req_vld,
  input  logic [31:0] ucb_dram_addr,
  input  logic [63:0] ucb_dram_data,
  input  logic        err_event,
  output logic        dram_ucb_ack_vld,
  output logic        dram_ucb_nack_vld,
  output logic [63:0] dram_ucb_data,
  output logic        l2if_err_intr,
  output logic [31:0] csr_cfg,
  output logic [12:0] csr_rfsh_int
);

  localparam logic [8:0] IDX_CFG      = 9'd0;
  localparam logic [8:0] IDX_RFSH_INT = 9'd1;
  localparam logic [8:0] IDX_ERR_CNT  = 9'd2;
  localparam logic [8:0] IDX_ERR_MAX  = 9'd3;
  localparam logic [8:0] IDX_ERR_STAT = 9'd4;

  localparam logic [12:0] RFSH_RST = 13'h0C30;
  localparam logic [2:0]  LAT_LOAD = 3'(RD_LAT - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rd_state_e;

  rd_state_e             r_state;
  logic [2:0]            r_lat_cnt;
  logic [8:0]            r_rd_idx;
  logic                  r_rd_mapped;
  logic                  r_ack;
  logic                  r_nack;
  logic                  r_intr;

  logic [31:0]           r_cfg;
  logic [12:0]           r_rfsh_int;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ERR_CNT_W-1:0]  r_err_max;
  logic [1:0]            r_err_stat;   // {INTR_SEEN, OVF}

  logic [8:0]            w_idx;
  logic                  w_mapped;
  logic                  w_wr_cfg;
  logic                  w_wr_rfsh;
  logic                  w_wr_cnt;
  logic                  w_wr_max;
  logic                  w_wr_stat;
  logic                  w_rd_accept;
  logic                  w_cnt_sat;
  logic [ERR_CNT_W-1:0]  w_cnt_inc;
  logic                  w_cnt_evt;
  logic                  w_fire;
  logic                  w_ovf_set;
  logic [1:0]            w_stat_clr;
  logic [1:0]            w_stat_nxt;
  logic [63:0]           w_rd_data;
  logic                  w_unused_ok;

  assign w_idx     = ucb_dram_addr[11:3];
  assign w_mapped  = (w_idx <= IDX_ERR_STAT);
  assign w_wr_cfg  = ucb_dram_wr_req_vld && (w_idx == IDX_CFG);
  assign w_wr_rfsh = ucb_dram_wr_req_vld && (w_idx == IDX_RFSH_INT);
  assign w_wr_cnt  = ucb_dram_wr_req_vld && (w_idx == IDX_ERR_CNT);
  assign w_wr_max  = ucb_dram_wr_req_vld && (w_idx == IDX_ERR_MAX);
  assign w_wr_stat = ucb_dram_wr_req_vld && (w_idx == IDX_ERR_STAT);

  // A simultaneous write takes the request slot, so the read is dropped.
  assign w_rd_accept = ucb_dram_rd_req_vld && !ucb_dram_wr_req_vld;

  // An ERR_CNT write in the same cycle swallows the event entirely.
  assign w_cnt_evt = err_event && !w_wr_cnt;
  assign w_cnt_sat = &r_err_cnt;
  assign w_cnt_inc = r_err_cnt + CNT_ONE;
  assign w_ovf_set = w_cnt_evt && w_cnt_sat;
  // Equality only on a real increment means one pulse per crossing; the count
  // must be rewritten below ERR_MAX before it can fire again.
  assign w_fire    = w_cnt_evt && !w_cnt_sat && (w_cnt_inc == r_err_max) &&
                     (r_err_max != '0);

  assign w_stat_clr = w_wr_stat ? ucb_dram_data[1:0] : 2'b00;
  assign w_stat_nxt = (r_err_stat & ~w_stat_clr) | {w_fire, w_ovf_set};

  assign w_unused_ok = ^{ucb_dram_addr[31:12], ucb_dram_addr[2:0],
                         ucb_dram_data[63:32]};

  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates see the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cfg      <= '0;
      r_rfsh_int <= RFSH_RST;
      r_err_cnt  <= '0;
      r_err_max  <= '1;
      r_err_stat <= '0;
      r_intr     <= 1'b0;
    end else begin
      if (w_wr_cfg)  r_cfg      <= ucb_dram_data[31:0];
      if (w_wr_rfsh) r_rfsh_int <= ucb_dram_data[12:0];
      if (w_wr_max)  r_err_max  <= ucb_dram_data[ERR_CNT_W-1:0];
      if (w_wr_cnt)       r_err_cnt <= ucb_dram_data[ERR_CNT_W-1:0];
      else if (w_cnt_evt && !w_cnt_sat) r_err_cnt <= w_cnt_inc;
      r_err_stat <= w_stat_nxt;
      r_intr     <= w_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      r_rd_idx    <= '0;
      r_rd_mapped <= 1'b0;
      r_ack       <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_rd_accept) begin
            r_rd_idx    <= w_idx;
            r_rd_mapped <= w_mapped;
            if (RD_LAT == 1) begin
              r_state <= ST_RESP;
              r_ack   <= w_mapped;
              r_nack  <= !w_mapped;
            end else begin
              r_state   <= ST_WAIT;
              r_lat_cnt <= LAT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == 3'd1) begin
            r_state <= ST_RESP;
            r_ack   <= r_rd_mapped;
            r_nack  <= !r_rd_mapped;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: default assignment first keeps this combinational mux latch-free.
  always_comb begin
    w_rd_data = '0;
    case (r_rd_idx)
      IDX_CFG:      w_rd_data[31:0]          = r_cfg;
      IDX_RFSH_INT: w_rd_data[12:0]          = r_rfsh_int;
      IDX_ERR_CNT:  w_rd_data[ERR_CNT_W-1:0] = r_err_cnt;
      IDX_ERR_MAX:  w_rd_data[ERR_CNT_W-1:0] = r_err_max;
      IDX_ERR_STAT: w_rd_data[1:0]           = r_err_stat;
      default:      w_rd_data                = '0;
    endcase
  end

  // Data reflects the register in the response cycle itself, so a write
  // landing on the preceding edge is visible.
  assign dram_ucb_data     = r_ack ? w_rd_data : '0;
  assign dram_ucb_ack_vld  = r_ack;
  assign dram_ucb_nack_vld = r_nack;
  assign l2if_err_intr     = r_intr;
  assign csr_cfg           = r_cfg;
  assign csr_rfsh_int      = r_rfsh_int;

endmodule
